issue_steer_buffer: RTL

ISSUE_STEER_BUFFER -- requirements
Module: issue_steer_buffer

---
 rtl/issue_steer_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/issue_steer_buffer.sv
// Decoded-instruction queue that steers the oldest entries to the branch and memory issue pipes.
// Dual issue of head+1 alongside head is enabled by defining ISSUE_DUAL_ISSUE_EN.

module issue_pipe_reg #(
  parameter int EW = 81
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          stall,
  input  logic          load,
  input  logic [EW-1:0] ent_in,
  output logic          valid,
  output logic [EW-1:0] ent_q
);
  // Stall freezes the whole register; an unstalled cycle with nothing steered becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ent_q <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= load;
      if (load) ent_q <= ent_in;
    end
  end
endmodule

module issue_steer_buffer #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 dec_valid,
  input  logic [3:0]                 dec_class,
  input  logic [9:0]                 dec_rs1,
  input  logic [9:0]                 dec_rs2,
  input  logic [9:0]                 dec_rd,
  input  logic [2*PAYLOAD_W-1:0]     dec_payload,
  output logic                       dec_ready,
  input  logic                       stall_branch,
  input  logic                       stall_memory,
  input  logic                       flush,
  output logic                       iss_br_valid,
  output logic [4:0]                 iss_br_rs1,
  output logic [4:0]                 iss_br_rs2,
  output logic [4:0]                 iss_br_rd,
  output logic [1:0]                 iss_br_class,
  output logic [PAYLOAD_W-1:0]       iss_br_payload,
  output logic                       iss_mem_valid,
  output logic [4:0]                 iss_mem_rs1,
  output logic [4:0]                 iss_mem_rs2,
  output logic [4:0]                 iss_mem_rd,
  output logic [1:0]                 iss_mem_class,
  output logic [PAYLOAD_W-1:0]       iss_mem_payload,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 17 + PAYLOAD_W;
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;

  // Entry layout: {class, rs1, rs2, rd, payload}
  logic [EW-1:0]       q_mem [DEPTH];
  logic [PW-1:0]       head, tail, head_nx, tail_nx;
  logic [CW-1:0]       count;
  logic [1:0][EW-1:0]  slot_ent;
  logic [EW-1:0]       h_ent, h1_ent;
  logic [1:0]          h_cls;
  logic                h_vld, h_br, h_mem, h1_br, h1_mem;
  logic                enq_ok;
  logic [1:0]          enq_n, deq_n;
  logic [1:0]          pipe_load, pipe_stall, pipe_vld;
  logic [1:0][EW-1:0]  pipe_in, pipe_q;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign slot_ent[s] = {dec_class[2*s +: 2], dec_rs1[5*s +: 5], dec_rs2[5*s +: 5],
                          dec_rd[5*s +: 5], dec_payload[PAYLOAD_W*s +: PAYLOAD_W]};
  end

  assign dec_ready = (count <= CW'(DEPTH - 2));
  assign occupancy = count;
  assign head_nx   = head + 1'b1;
  assign tail_nx   = tail + 1'b1;
  assign h_ent     = q_mem[head];
  assign h1_ent    = q_mem[head_nx];
  assign h_cls     = h_ent[EW-1 -: 2];
  assign h_vld     = (count != '0);

  // ALU prefers the branch pipe and falls back to memory only when branch is stalled.
  assign h_br  = h_vld && !stall_branch && (h_cls == CLS_BR || h_cls == CLS_ALU);
  assign h_mem = h_vld && !stall_memory && (h_cls[1] || (h_cls == CLS_ALU && stall_branch));

`ifdef ISSUE_DUAL_ISSUE_EN
  logic [1:0] h1_cls;
  logic [4:0] h_rd, h1_rs1, h1_rs2;
  logic       h1_vld, hazard;
  assign h1_cls = h1_ent[EW-1 -: 2];
  assign h1_rs1 = h1_ent[EW-3 -: 5];
  assign h1_rs2 = h1_ent[EW-8 -: 5];
  assign h_rd   = h_ent[EW-13 -: 5];
  assign h1_vld = (count >= CW'(2));
  assign hazard = (h_rd != 5'd0) && (h1_rs1 == h_rd || h1_rs2 == h_rd);
  // head+1 may only take the pipe head left free, which keeps same-class pairs apart.
  assign h1_br  = h1_vld && h_mem && !hazard && !stall_branch && !h1_cls[1];
  assign h1_mem = h1_vld && h_br && !hazard && !stall_memory && (h1_cls[1] || h1_cls == CLS_ALU);
`else
  assign h1_br  = 1'b0;
  assign h1_mem = 1'b0;
`endif

  assign deq_n  = {1'b0, h_br | h_mem} + {1'b0, h1_br | h1_mem};
  assign enq_ok = dec_ready && !flush;
  assign enq_n  = enq_ok ? ({1'b0, dec_valid[0]} + {1'b0, dec_valid[1]}) : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (enq_ok && dec_valid[0]) q_mem[tail] <= slot_ent[0];
    if (enq_ok && dec_valid[1]) q_mem[dec_valid[0] ? tail_nx : tail] <= slot_ent[1];
  end

  assign pipe_load  = {h_mem | h1_mem, h_br | h1_br};
  assign pipe_stall = {stall_memory, stall_branch};
  assign pipe_in[0] = h_br  ? h_ent : h1_ent;
  assign pipe_in[1] = h_mem ? h_ent : h1_ent;

  for (genvar p = 0; p < 2; p++) begin : g_pipe
    issue_pipe_reg #(.EW(EW)) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .stall  (pipe_stall[p]),
      .load   (pipe_load[p]),
      .ent_in (pipe_in[p]),
      .valid  (pipe_vld[p]),
      .ent_q  (pipe_q[p])
    );
  end

  assign iss_br_valid  = pipe_vld[0];
  assign iss_mem_valid = pipe_vld[1];
  assign {iss_br_class, iss_br_rs1, iss_br_rs2, iss_br_rd, iss_br_payload}       = pipe_q[0];
  assign {iss_mem_class, iss_mem_rs1, iss_mem_rs2, iss_mem_rd, iss_mem_payload}  = pipe_q[1];
endmodule
